// File: rtl/pcw_dn_pkg.sv
// Shared types and constants for the PCW download-port arbiter.
package pcw_dn_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BOOT_RD = 3'd1,
      BOOT_WR = 3'd2,
      EXEC    = 3'd3,
      HPS     = 3'd4
   } dn_state_t;

   localparam logic [127:0] PAL_DEFAULT = 128'h00000032cd320000ff00ffff00000000;
   localparam int ROM_LAT_MAX = 3;
   localparam int LAT_W       = $clog2(ROM_LAT_MAX + 1);

endpackage

// File: rtl/pcw_dn_hold.sv
// Single-entry address/data hold register for HPS download bytes.
module pcw_dn_hold #(
   parameter int ADDR_W = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              load,
   input  logic              accept,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              full,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data
);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         addr <= ld_addr;
         data <= ld_data;
      end else if (accept) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/pcw_dn_arbiter.sv
// Sequences the boot-ROM copy and HPS ROM download onto the core's download port.
// Optional PCW_DN_PALETTE_EN: capture PAL_INDEX bytes into the palette shift register.
//
// state   | meaning
// IDLE    | port free; boot copy has priority over HPS
// BOOT_RD | boot ROM read in flight, latency down-counter running
// BOOT_WR | boot byte presented, waiting for dn_ready
// EXEC    | one-cycle execute strobe
// HPS     | HPS download granted, bytes flow through hold register
module pcw_dn_arbiter
   import pcw_dn_pkg::*;
#(
   parameter int          BOOT_ROM_END = 275,
   parameter int          ADDR_W       = 16,
   parameter int          ROM_LAT      = 1,
   parameter logic [15:0] EXEC_ADDR    = 16'h0000,
   parameter logic [7:0]  ROM_INDEX    = 8'd0,
   parameter logic [7:0]  PAL_INDEX    = 8'd3
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              boot_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_data,
   output logic              ioctl_wait,
   input  logic              dn_ready,
   output logic              dn_go,
   output logic              dn_wr,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic [15:0]       execute_addr,
   output logic              execute_enable,
   output logic [127:0]      palette
);

   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(ROM_LAT - 1);
   localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(BOOT_ROM_END);

   dn_state_t         state, state_nxt;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
   logic [LAT_W-1:0]  lat_q, lat_nxt;
   logic [ADDR_W-1:0] boot_addr_q, boot_addr_nxt;
   logic [7:0]        boot_data_q, boot_data_nxt;
   logic              boot_pending_q, boot_pending_nxt;

   logic              hold_full, hold_load, hold_accept;
   logic [ADDR_W-1:0] hold_addr;
   logic [7:0]        hold_data;
   logic              rom_hit, pal_hit, in_hps;

   assign in_hps  = (state == HPS);
   assign pal_hit = ioctl_wr && (ioctl_index == PAL_INDEX);
   // Palette index takes precedence so ROM_INDEX==PAL_INDEX never double-books a byte.
   assign rom_hit = ioctl_wr && (ioctl_index == ROM_INDEX) && !pal_hit;

   assign hold_accept = in_hps && hold_full && dn_ready;
   assign hold_load   = in_hps && rom_hit && (!hold_full || hold_accept);

   pcw_dn_hold #(.ADDR_W(ADDR_W)) u_hold (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .load    (hold_load),
      .accept  (hold_accept),
      .ld_addr (ioctl_addr),
      .ld_data (ioctl_data),
      .full    (hold_full),
      .addr    (hold_addr),
      .data    (hold_data)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         rom_addr_q     <= '0;
         lat_q          <= '0;
         boot_addr_q    <= '0;
         boot_data_q    <= '0;
         boot_pending_q <= 1'b1;
      end else begin
         state          <= state_nxt;
         rom_addr_q     <= rom_addr_nxt;
         lat_q          <= lat_nxt;
         boot_addr_q    <= boot_addr_nxt;
         boot_data_q    <= boot_data_nxt;
         boot_pending_q <= boot_pending_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      rom_addr_nxt     = rom_addr_q;
      lat_nxt          = lat_q;
      boot_addr_nxt    = boot_addr_q;
      boot_data_nxt    = boot_data_q;
      boot_pending_nxt = boot_pending_q;
      case (state)
         IDLE: begin
            if (boot_pending_q || boot_req) begin
               state_nxt        = BOOT_RD;
               rom_addr_nxt     = '0;
               lat_nxt          = LAT_LOAD;
               boot_pending_nxt = 1'b1;
            end else if (ioctl_download) begin
               state_nxt = HPS;
            end
         end
         BOOT_RD: begin
            if (lat_q == '0) begin
               boot_data_nxt = rom_data;
               boot_addr_nxt = rom_addr_q;
               state_nxt     = BOOT_WR;
            end else begin
               lat_nxt = lat_q - LAT_W'(1);
            end
         end
         BOOT_WR: begin
            if (dn_ready) begin
               if (rom_addr_q == END_ADDR) begin
                  boot_pending_nxt = 1'b0;
                  state_nxt        = EXEC;
               end else begin
                  rom_addr_nxt = rom_addr_q + ADDR_W'(1);
                  lat_nxt      = LAT_LOAD;
                  state_nxt    = BOOT_RD;
               end
            end
         end
         EXEC: state_nxt = IDLE;
         HPS: begin
            if (boot_req) boot_pending_nxt = 1'b1;
            if (!ioctl_download && !hold_full) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rom_addr       = rom_addr_q;
   assign dn_go          = (state == BOOT_RD) || (state == BOOT_WR) || in_hps;
   assign dn_wr          = (state == BOOT_WR) || (in_hps && hold_full);
   assign dn_addr        = in_hps ? hold_addr : boot_addr_q;
   assign dn_data        = in_hps ? hold_data : boot_data_q;
   assign execute_enable = (state == EXEC);
   assign execute_addr   = EXEC_ADDR;
   // Outside HPS any pending download is stalled until the port is granted.
   assign ioctl_wait     = in_hps ? hold_full : ioctl_download;

`ifdef PCW_DN_PALETTE_EN
   logic [127:0] palette_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         palette_q <= PAL_DEFAULT;
      end else if (in_hps && pal_hit) begin
         palette_q <= {palette_q[119:0], ioctl_data};
      end
   end

   assign palette = palette_q;
`else
   assign palette = PAL_DEFAULT;
`endif

endmodule

// File: tb/tb_pcw_dn_arbiter.sv
// Directed bench for pcw_dn_arbiter: boot copy, stalls, HPS bytes, palette, re-boot, reset abort.
module tb_pcw_dn_arbiter;
   import pcw_dn_pkg::*;

   logic         clk_sys = 1'b0;
   logic         reset_n;
   logic         boot_req;
   logic [15:0]  rom_addr;
   logic [7:0]   rom_data;
   logic         ioctl_download;
   logic [7:0]   ioctl_index;
   logic         ioctl_wr;
   logic [15:0]  ioctl_addr;
   logic [7:0]   ioctl_data;
   logic         ioctl_wait;
   logic         dn_ready;
   logic         dn_go;
   logic         dn_wr;
   logic [15:0]  dn_addr;
   logic [7:0]   dn_data;
   logic [15:0]  execute_addr;
   logic         execute_enable;
   logic [127:0] palette;

   int n_err = 0;
   int n_chk = 0;

   int bc_writes, bc_bad, bc_exec, bc_pulses, bc_wait_bad;

   typedef struct {
      logic [7:0]  idx;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        exp_wr;
   } hps_vec_t;

   hps_vec_t vec[7];

   always #5 clk_sys = ~clk_sys;

   function automatic logic [7:0] rom_fn(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd37 + 16'h0011;
      return t[7:0] ^ a[15:8];
   endfunction

   assign rom_data = rom_fn(rom_addr);

   pcw_dn_arbiter dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .boot_req       (boot_req),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wait     (ioctl_wait),
      .dn_ready       (dn_ready),
      .dn_go          (dn_go),
      .dn_wr          (dn_wr),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .execute_addr   (execute_addr),
      .execute_enable (execute_enable),
      .palette        (palette)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs until 3 cycles after execute_enable (or 2000 cycles), tracking every accepted write.
   task automatic boot_copy(input int stall_byte, input int dl_at);
      logic [15:0] exp_addr;
      logic [7:0]  held_d;
      int          stall_cnt;
      exp_addr    = 16'h0000;
      held_d      = 8'h00;
      stall_cnt   = 0;
      bc_writes   = 0;
      bc_bad      = 0;
      bc_exec     = -1;
      bc_pulses   = 0;
      bc_wait_bad = 0;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk_sys);
         if (dn_wr && !dn_go) bc_bad++;
         if (execute_enable) begin
            bc_pulses++;
            if (bc_exec < 0) bc_exec = cyc;
            if (dn_go) bc_bad++;
         end
         if (dl_at > 0 && cyc > dl_at && bc_exec < 0 && !ioctl_wait) bc_wait_bad++;
         if (dl_at == cyc) ioctl_download = 1'b1;
         if (dn_wr) begin
            if (stall_byte >= 0 && dn_addr == 16'(stall_byte) && stall_cnt < 5) begin
               if (stall_cnt > 0 && dn_data !== held_d) bc_bad++;
               held_d    = dn_data;
               stall_cnt++;
               dn_ready  = 1'b0;
            end else begin
               dn_ready = 1'b1;
               if (dn_addr !== exp_addr || dn_data !== rom_fn(exp_addr)) bc_bad++;
               exp_addr++;
               bc_writes++;
            end
         end else begin
            dn_ready = 1'b1;
         end
         if (bc_exec >= 0 && cyc == bc_exec + 3) break;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [127:0] exp_pal;
      int pal_bad;
      int found;

      vec[0] = '{8'd0,  16'h1234, 8'hA5, 1'b1};
      vec[1] = '{8'd0,  16'h1235, 8'h5A, 1'b1};
      vec[2] = '{8'd1,  16'h2000, 8'h77, 1'b0};
      vec[3] = '{8'd3,  16'h0010, 8'h33, 1'b0};
      vec[4] = '{8'd0,  16'hFFFF, 8'hC3, 1'b1};
      vec[5] = '{8'h40, 16'h0000, 8'h11, 1'b0};
      vec[6] = '{8'd0,  16'h0000, 8'h00, 1'b1};

      reset_n        = 1'b0;
      boot_req       = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = 16'h0000;
      ioctl_data     = 8'h00;
      dn_ready       = 1'b1;

      // Reset values
      repeat (3) @(negedge clk_sys);
      chk("rst_dn_go", dn_go, 0);
      chk("rst_dn_wr", dn_wr, 0);
      chk("rst_dn_addr", dn_addr, 0);
      chk("rst_dn_data", dn_data, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_ioctl_wait", ioctl_wait, 0);
      chk("rst_exec_en", execute_enable, 0);
      chk("rst_exec_addr", execute_addr, 16'h0000);
      chk("rst_palette", palette, PAL_DEFAULT);
      reset_n = 1'b1;

      // Plain boot copy
      boot_copy(-1, -1);
      chk("boot_writes", bc_writes, 276);
      chk("boot_bad", bc_bad, 0);
      chk("boot_exec_cycle", bc_exec, 553);
      chk("boot_exec_pulses", bc_pulses, 1);
      chk("boot_go_after", dn_go, 0);
      chk("boot_rom_addr_end", rom_addr, 275);

      // Reset while byte 100 is on the port
      do_reset();
      found = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk_sys);
         if (dn_wr && dn_addr == 16'd100) begin
            found = 1;
            break;
         end
      end
      chk("rst100_reached", found, 1);
      reset_n = 1'b0;
      #1;
      chk("rst100_dn_go", dn_go, 0);
      chk("rst100_dn_wr", dn_wr, 0);
      chk("rst100_dn_addr", dn_addr, 0);
      chk("rst100_dn_data", dn_data, 0);
      chk("rst100_rom_addr", rom_addr, 0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      boot_copy(-1, -1);
      chk("rst100_writes", bc_writes, 276);
      chk("rst100_bad", bc_bad, 0);
      chk("rst100_exec_cycle", bc_exec, 553);

      // Stall at byte 10, HPS download requested at cycle 20
      do_reset();
      boot_copy(10, 20);
      chk("stall_writes", bc_writes, 276);
      chk("stall_bad", bc_bad, 0);
      chk("stall_exec_cycle", bc_exec, 558);
      chk("stall_exec_pulses", bc_pulses, 1);
      chk("dl_wait_during_boot", bc_wait_bad, 0);
      chk("dl_granted_go", dn_go, 1);
      chk("dl_granted_wait", ioctl_wait, 0);

      // HPS byte table
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_sys);
         ioctl_wr    = 1'b1;
         ioctl_index = vec[i].idx;
         ioctl_addr  = vec[i].addr;
         ioctl_data  = vec[i].data;
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         chk($sformatf("vec%0d_wr", i), dn_wr, vec[i].exp_wr);
         chk($sformatf("vec%0d_wait", i), ioctl_wait, vec[i].exp_wr);
         if (vec[i].exp_wr) begin
            chk($sformatf("vec%0d_addr", i), dn_addr, vec[i].addr);
            chk($sformatf("vec%0d_data", i), dn_data, vec[i].data);
         end
         @(negedge clk_sys);
         chk($sformatf("vec%0d_drained", i), dn_wr, 0);
      end

      // Palette bytes on index 3
      pal_bad = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_sys);
         if (dn_wr || ioctl_wait) pal_bad++;
         ioctl_wr    = 1'b1;
         ioctl_index = 8'd3;
         ioctl_addr  = 16'(i);
         ioctl_data  = 8'(i);
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (dn_wr || ioctl_wait) pal_bad++;
`ifdef PCW_DN_PALETTE_EN
      exp_pal = 128'h000102030405060708090A0B0C0D0E0F;
`else
      exp_pal = PAL_DEFAULT;
`endif
      chk("pal_no_wr_wait", pal_bad, 0);
      chk("pal_value", palette, exp_pal);

      // boot_req during HPS, with a byte still held when the download ends
      @(negedge clk_sys);
      ioctl_wr    = 1'b1;
      ioctl_index = 8'd0;
      ioctl_addr  = 16'h4000;
      ioctl_data  = 8'h99;
      dn_ready    = 1'b0;
      boot_req    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr       = 1'b0;
      boot_req       = 1'b0;
      ioctl_download = 1'b0;
      chk("reboot_hold_wr", dn_wr, 1);
      chk("reboot_hold_addr", dn_addr, 16'h4000);
      chk("reboot_hold_wait", ioctl_wait, 1);
      repeat (3) @(negedge clk_sys);
      chk("reboot_held_wr", dn_wr, 1);
      chk("reboot_held_data", dn_data, 8'h99);
      chk("reboot_held_go", dn_go, 1);
      dn_ready = 1'b1;
      boot_copy(-1, -1);
      chk("reboot_writes", bc_writes, 276);
      chk("reboot_bad", bc_bad, 0);
      chk("reboot_exec_cycle", bc_exec, 555);
      chk("reboot_exec_pulses", bc_pulses, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pcw_dn_arbiter.md
Name: pcw_dn_arbiter

Overview:
- Sequences and shares the core's single download write port (dn_go/dn_wr/dn_addr/dn_data) between two requesters.
- Requester 1 is the internal boot-ROM copier, which runs after every reset and re-boot request. Requester 2 is the HPS ioctl ROM download.
- Issues the one-cycle execute_enable strobe once the boot image is fully written.
- Replaces the ad-hoc loader logic in the top level and sits between hps_io/boot_loader and pcw_core.

Parameters:
- BOOT_ROM_END, 275: last boot-ROM byte address, inclusive. 276 bytes are copied.
- ADDR_W, 16: width of dn_addr, rom_addr and ioctl_addr.
- ROM_LAT, 1: cycles from rom_addr change to valid rom_data (1..3).
- EXEC_ADDR, 16'h0000: value driven on execute_addr.
- ROM_INDEX, 8'd0: ioctl_index routed to core memory.
- PAL_INDEX, 8'd3: ioctl_index captured as palette (feature only).

Ports:
- clk_sys  in  1  system clock, 32 MHz
- reset_n  in  1  asynchronous, active-low reset
- boot_req  in  1  single-cycle request to re-run the boot copy
- rom_addr  out  ADDR_W  boot ROM read address
- rom_data  in  8  boot ROM data, valid ROM_LAT cycles after rom_addr
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  HPS download target
- ioctl_wr  in  1  HPS byte strobe
- ioctl_addr  in  ADDR_W  HPS byte address
- ioctl_data  in  8  HPS byte
- ioctl_wait  out  1  backpressure to HPS
- dn_ready  in  1  core accepts dn_wr this cycle
- dn_go  out  1  download window active
- dn_wr  out  1  write request, held until accepted
- dn_addr  out  ADDR_W  write address
- dn_data  out  8  write data
- execute_addr  out  16  start address for the core
- execute_enable  out  1  one-cycle execute strobe
- palette  out  128  fake-colour palette

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: dn_go=0, dn_wr=0, dn_addr=0, dn_data=0, rom_addr=0, ioctl_wait=0, execute_enable=0, execute_addr=EXEC_ADDR, palette=PAL_DEFAULT.
  - State: IDLE, boot_pending=1, hold register empty.
  - Reset mid-copy or mid-HPS aborts with no trailing write; after release the boot copy restarts at address 0.
- States: IDLE, BOOT_RD, BOOT_WR, EXEC, HPS.
- IDLE:
  - If boot_pending: go to BOOT_RD with rom_addr=0.
  - Else if ioctl_download: go to HPS.
  - Boot has priority when both are pending in the same cycle.
- BOOT_RD:
  - dn_go=1. Wait ROM_LAT cycles, then latch rom_data into dn_data, set dn_addr=rom_addr, dn_wr=1, go to BOOT_WR.
- BOOT_WR:
  - Hold dn_wr/dn_addr/dn_data stable while dn_ready=0.
  - On dn_wr&dn_ready: dn_wr<=0.
  - If rom_addr==BOOT_ROM_END: dn_go<=0, boot_pending<=0, go to EXEC.
  - Else: rom_addr+1, go to BOOT_RD.
  - Throughput with dn_ready=1 and ROM_LAT=1 is 2 cycles/byte, 552 cycles total.
- EXEC:
  - execute_enable=1 for exactly one cycle, then IDLE.
- HPS:
  - dn_go=1 while granted.
  - ioctl_wr with ioctl_index==ROM_INDEX loads the one-entry hold register; ioctl_wait=1 while it is full.
  - A full hold register drives dn_wr/dn_addr=ioctl_addr/dn_data. It empties on dn_ready.
  - Other indices are consumed and discarded with no dn_wr (palette excepted, see feature).
  - When ioctl_download falls, drain the hold register first, then dn_go<=0 and go to IDLE. No execute strobe.
- ioctl_wait=1 whenever ioctl_download=1 and the HPS is not granted (boot in progress).
- boot_req:
  - In IDLE or HPS: sets boot_pending. During HPS it is served after HPS ends.
  - During BOOT_RD/BOOT_WR/EXEC: ignored.
- Address arithmetic is unsigned ADDR_W and never wraps, since BOOT_ROM_END < 2^ADDR_W.
- dn_wr never asserts while dn_go=0.

Optional Feature:
- Macro: PCW_DN_PALETTE_EN.
- Defined: ioctl_wr with ioctl_index==PAL_INDEX shifts ioctl_data into palette, as {palette[119:0],data}, in one cycle. ioctl_wait is never raised for these bytes.
- Undefined: palette is tied to PAL_DEFAULT, and PAL_INDEX bytes are discarded like any other non-ROM index.

Decomposition:
- Package pcw_dn_pkg holds:
  - dn_state_t enum {IDLE,BOOT_RD,BOOT_WR,EXEC,HPS}
  - PAL_DEFAULT=128'h00000032cd320000ff00ffff00000000
  - ROM_LAT_MAX=3
- One sub-module, pcw_dn_hold: a single-entry addr/data hold register with full flag, load and accept. It is used for the HPS path.

Test Plan:
- Release reset, dn_ready=1, ROM_LAT=1 -> 276 writes at dn_addr 0..275 matching rom_data; dn_go falls after write 275; execute_enable high exactly 1 cycle, 2 cycles later, execute_addr=0000.
- dn_ready low for 5 cycles at byte 10 -> dn_wr/dn_addr=10/dn_data held stable; no skip or duplicate; total writes still 276.
- ioctl_download asserted at cycle 20 of boot -> ioctl_wait=1 until execute_enable; then HPS bytes 0x1234=0xA5, 0x1235=0x5A are written in order, ioctl_wait high 1 cycle each.
- boot_req during HPS download with index 0 -> HPS completes and its hold register drains, then a full boot copy runs and execute_enable pulses once.
- reset_n low at byte 100 -> all outputs at reset values immediately; after release the copy restarts at address 0.
- With PCW_DN_PALETTE_EN, 16 bytes 0x00..0x0F on index 3 -> palette=128'h000102030405060708090A0B0C0D0E0F, no dn_wr, ioctl_wait=0; without the macro, palette stays PAL_DEFAULT.
